eink_sclk_sched: RTL and testbench

//  Sequences the source-driver shift clock (SCLK) for one panel line: emits exactly

---
 rtl/eink_sclk_sched_pkg.sv | 19 +
 rtl/eink_sclk_sched_if.sv | 32 +++
 rtl/eink_sclk_sched_phase_gen.sv | 60 ++++++
 rtl/eink_sclk_sched.sv | 148 ++++++++++++++
 tb/tb_eink_sclk_sched.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/eink_sclk_sched_pkg.sv
// Shared types and constants for the e-ink source-driver SCLK scheduler.
package eink_sclk_sched_pkg;

    // Default widths used by the interface and the top-level
    localparam int DIV_W_DEF = 8;
    localparam int CNT_W_DEF = 12;

    // Divisor loaded at reset, and the smallest divisor that still gives
    // one high and one low clk cycle per SCLK period
    localparam int DEFAULT_DIV = 5;
    localparam int MIN_DIV     = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/eink_sclk_sched_if.sv
// Bundle of the scheduler's handshake and output signals.
//
// cfg handshake: a divisor transfer happens in a cycle where cfg_valid and
// cfg_ready are both high at the rising clk edge; cfg_div must be stable while
// cfg_valid is high; cfg_ready is only high while the scheduler is idle.
interface eink_sclk_sched_if #(
    parameter int DIV_W = 8,
    parameter int CNT_W = 12
);
    logic [DIV_W-1:0] cfg_div;
    logic             cfg_valid;
    logic             cfg_ready;
    logic             start;
    logic [CNT_W-1:0] burst_len;
    logic             busy;
    logic             done;
    logic             sclk;
    logic             sclk_rise;
    logic             sclk_fall;

    // Line timing FSM / pixel shifter side
    modport master (
        output cfg_div, cfg_valid, start, burst_len,
        input  cfg_ready, busy, done, sclk, sclk_rise, sclk_fall
    );

    // Scheduler side
    modport slave (
        input  cfg_div, cfg_valid, start, burst_len,
        output cfg_ready, busy, done, sclk, sclk_rise, sclk_fall
    );
endinterface

// File: rtl/eink_sclk_sched_phase_gen.sv
// Phase counter for one SCLK period plus registered sclk/rise/fall decode.
// load restarts the period at phase 0, en advances one phase, clr forces
// everything low (clr wins over load, load wins over en).
module eink_sclk_sched_phase_gen #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             en,
    input  logic             clr,
    input  logic [DIV_W-1:0] div,
    output logic             wrap,
    output logic             sclk,
    output logic             sclk_rise,
    output logic             sclk_fall
);
    logic [DIV_W-1:0] ph_q;
    logic [DIV_W-1:0] ph_next;
    logic [DIV_W-1:0] half;

    // High phase is the first div>>1 cycles of each period
    assign half = div >> 1;

    // Current cycle is the last one of an SCLK period
    assign wrap = en && (ph_q == div - DIV_W'(1));

    // Next phase: 0 on load or wrap, otherwise increment
    always_comb begin
        ph_next = '0;
        if (load) begin
            ph_next = '0;
        end else if (ph_q == div - DIV_W'(1)) begin
            ph_next = '0;
        end else begin
            ph_next = ph_q + DIV_W'(1);
        end
    end

    // Phase register and outputs decoded from the phase being entered
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ph_q      <= '0;
            sclk      <= 1'b0;
            sclk_rise <= 1'b0;
            sclk_fall <= 1'b0;
        end else if (clr) begin
            ph_q      <= '0;
            sclk      <= 1'b0;
            sclk_rise <= 1'b0;
            sclk_fall <= 1'b0;
        end else if (load || en) begin
            ph_q      <= ph_next;
            sclk      <= (ph_next < half);
            sclk_rise <= (ph_next == '0);
            sclk_fall <= (ph_next == half);
        end
    end

endmodule

// File: rtl/eink_sclk_sched.sv
// SCLK burst scheduler: emits burst_len SCLK periods at divisor div_q per
// start request, then pulses done. Divisor updates are accepted only while
// idle and take effect from the next burst.
module eink_sclk_sched
    import eink_sclk_sched_pkg::*;
#(
    parameter int DIV_W       = DIV_W_DEF,
    parameter int CNT_W       = CNT_W_DEF,
    parameter int DEFAULT_DIV = eink_sclk_sched_pkg::DEFAULT_DIV
) (
    input  logic                    clk,
    input  logic                    reset,
    eink_sclk_sched_if.slave        bus,
    output state_t                  dbg_state
);
    state_t           state_q;
    state_t           state_next;

    logic [DIV_W-1:0] div_q;       // divisor for the next burst
    logic [DIV_W-1:0] bdiv_q;      // divisor frozen for the running burst
    logic [CNT_W-1:0] len_q;       // periods requested for the running burst
    logic [CNT_W-1:0] pcnt_q;      // completed periods, 0..len_q-1

    logic             accept;      // start seen while idle
    logic             ph_load;
    logic             ph_en;
    logic             ph_clr;
    logic             ph_wrap;
    logic             last_period;
    logic [DIV_W-1:0] ph_div;
    logic             sclk;
    logic             sclk_rise;
    logic             sclk_fall;

    assign accept      = (state_q == ST_IDLE) && bus.start;
    assign last_period = ph_wrap && (pcnt_q == len_q - CNT_W'(1));

    // While idle the load uses the current divisor; afterwards the frozen copy,
    // so a same-cycle divisor update cannot disturb the burst it races with
    assign ph_div = (state_q == ST_IDLE) ? div_q : bdiv_q;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_next = (bus.burst_len != '0) ? ST_RUN : ST_DONE;
                end
            end
            ST_RUN: begin
                if (last_period) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Outputs and phase generator controls decoded from the current state
    always_comb begin
        bus.cfg_ready = 1'b0;
        bus.busy      = 1'b0;
        bus.done      = 1'b0;
        ph_load       = 1'b0;
        ph_en         = 1'b0;
        ph_clr        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                bus.cfg_ready = 1'b1;
                ph_load       = bus.start && (bus.burst_len != '0);
            end
            ST_RUN: begin
                bus.busy = 1'b1;
                ph_en    = 1'b1;
                ph_clr   = last_period;
            end
            ST_DONE: begin
                bus.done = 1'b1;
            end
            default: begin
                ph_clr = 1'b1;
            end
        endcase
    end

    // Divisor register: clamp 0 and 1 up to the minimum usable divisor
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q <= DIV_W'(DEFAULT_DIV);
        end else if (bus.cfg_valid && bus.cfg_ready) begin
            div_q <= (bus.cfg_div < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : bus.cfg_div;
        end
    end

    // Burst parameters latched when a non-empty burst starts
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bdiv_q <= DIV_W'(DEFAULT_DIV);
            len_q  <= '0;
        end else if (accept && ph_load) begin
            bdiv_q <= div_q;
            len_q  <= bus.burst_len;
        end
    end

    // Completed-period counter; never exceeds len_q-1 so full-scale bursts fit
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pcnt_q <= '0;
        end else if (ph_load) begin
            pcnt_q <= '0;
        end else if (ph_wrap && !last_period) begin
            pcnt_q <= pcnt_q + CNT_W'(1);
        end
    end

    eink_sclk_sched_phase_gen #(
        .DIV_W (DIV_W)
    ) u_phase (
        .clk       (clk),
        .reset     (reset),
        .load      (ph_load),
        .en        (ph_en),
        .clr       (ph_clr),
        .div       (ph_div),
        .wrap      (ph_wrap),
        .sclk      (sclk),
        .sclk_rise (sclk_rise),
        .sclk_fall (sclk_fall)
    );

    assign bus.sclk      = sclk;
    assign bus.sclk_rise = sclk_rise;
    assign bus.sclk_fall = sclk_fall;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_eink_sclk_sched.sv
// Bench for eink_sclk_sched: the driver pushes an expected burst summary
// (done cycle, rises, high cycles, falls) per start; the monitor accumulates
// strobes and checks a summary every time done pulses.
module tb_eink_sclk_sched;
    import eink_sclk_sched_pkg::*;

    localparam int DIV_W = 8;
    localparam int CNT_W = 12;
    localparam int EXP_W = 64;

    logic   clk = 1'b0;
    logic   reset = 1'b1;
    state_t dbg_state;

    eink_sclk_sched_if #(.DIV_W(DIV_W), .CNT_W(CNT_W)) ifc();

    eink_sclk_sched #(
        .DIV_W       (DIV_W),
        .CNT_W       (CNT_W),
        .DEFAULT_DIV (5)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (ifc),
        .dbg_state (dbg_state)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard state
    logic [EXP_W-1:0] exp_q[$];
    int errors = 0;
    int checks = 0;
    int model_div = 5;
    int rises = 0;
    int highs = 0;
    int falls = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [EXP_W-1:0] make_exp(input int t0, input int len, input int d);
        logic [EXP_W-1:0] e;
        e[63:40] = 24'(t0 + len * d + 1);
        e[39:28] = 12'(len);
        e[27:12] = 16'(len * (d / 2));
        e[11:0]  = 12'(len);
        return e;
    endfunction

    function automatic int clamp_div(input int d);
        return (d < 2) ? 2 : d;
    endfunction

    // Monitor: runs at negedge, away from the active edge
    task automatic run_monitor();
        logic [EXP_W-1:0] e;
        forever begin
            @(negedge clk);
            if (reset) begin
                exp_q.delete();
                rises = 0;
                highs = 0;
                falls = 0;
            end else begin
                if (ifc.sclk_rise) rises++;
                if (ifc.sclk)      highs++;
                if (ifc.sclk_fall) falls++;
                if (ifc.sclk || ifc.sclk_rise || ifc.sclk_fall)
                    check("strobe_needs_busy", int'(ifc.busy), 1);
                if (ifc.done) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_done: done seen at cycle %0d, expected none", cyc);
                    end else begin
                        e = exp_q.pop_front();
                        check("done_cycle", cyc, int'(e[63:40]));
                        check("rise_count", rises, int'(e[39:28]));
                        check("high_cycles", highs, int'(e[27:12]));
                        check("fall_count", falls, int'(e[11:0]));
                    end
                    rises = 0;
                    highs = 0;
                    falls = 0;
                end
            end
        end
    endtask

    // Driver tasks
    task automatic send_cfg(input int d);
        @(posedge clk); #1;
        ifc.cfg_valid = 1'b1;
        ifc.cfg_div   = DIV_W'(d);
        @(negedge clk);
        check("cfg_ready_idle", int'(ifc.cfg_ready), 1);
        model_div = clamp_div(d);
        @(posedge clk); #1;
        ifc.cfg_valid = 1'b0;
    endtask

    task automatic poke_cfg_busy(input int d);
        @(posedge clk); #1;
        ifc.cfg_valid = 1'b1;
        ifc.cfg_div   = DIV_W'(d);
        @(negedge clk);
        check("cfg_ready_busy", int'(ifc.cfg_ready), 0);
        @(posedge clk); #1;
        ifc.cfg_valid = 1'b0;
    endtask

    task automatic start_burst(input int len, input bit do_cfg, input int cfg_val);
        @(posedge clk); #1;
        ifc.start     = 1'b1;
        ifc.burst_len = CNT_W'(len);
        if (do_cfg) begin
            ifc.cfg_valid = 1'b1;
            ifc.cfg_div   = DIV_W'(cfg_val);
        end
        exp_q.push_back(make_exp(cyc, len, model_div));
        if (do_cfg) model_div = clamp_div(cfg_val);
        @(posedge clk); #1;
        ifc.start     = 1'b0;
        ifc.cfg_valid = 1'b0;
    endtask

    task automatic stray_start();
        @(posedge clk); #1;
        ifc.start     = 1'b1;
        ifc.burst_len = CNT_W'(1);
        @(posedge clk); #1;
        ifc.start     = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) @(posedge clk);
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: %0d bursts still pending after %0d cycles", exp_q.size(), budget);
            exp_q.delete();
        end
    endtask

    initial begin
        ifc.cfg_div   = '0;
        ifc.cfg_valid = 1'b0;
        ifc.start     = 1'b0;
        ifc.burst_len = '0;

        fork
            run_monitor();
        join_none

        // Reset defaults
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs",
              int'({ifc.sclk, ifc.busy, ifc.done, ifc.sclk_rise, ifc.sclk_fall, ifc.cfg_ready}),
              int'(6'b000001));
        check("reset_state", int'(dbg_state), int'(ST_IDLE));
        @(posedge clk); #1;
        reset = 1'b0;

        // 1: default divisor 5, L=3 -> done at T+16
        start_burst(3, 1'b0, 0);
        wait_idle(100);

        // 2: divisor 2, L=4 -> done at T+9
        send_cfg(2);
        start_burst(4, 1'b0, 0);
        wait_idle(100);

        // 3: divisor 0 and 1 clamp to 2; update attempted while running is refused
        send_cfg(0);
        start_burst(2, 1'b0, 0);
        wait_idle(100);
        send_cfg(7);
        send_cfg(1);
        start_burst(6, 1'b0, 0);
        repeat (3) @(posedge clk);
        poke_cfg_busy(9);
        wait_idle(100);
        start_burst(1, 1'b0, 0);
        wait_idle(100);

        // 4: same-cycle start and cfg: burst at old divisor, next burst at new
        send_cfg(5);
        start_burst(2, 1'b1, 8);
        wait_idle(100);
        start_burst(2, 1'b0, 0);
        wait_idle(100);

        // 5: empty burst, then a start issued while busy is ignored
        send_cfg(5);
        start_burst(0, 1'b0, 0);
        wait_idle(100);
        start_burst(3, 1'b0, 0);
        repeat (3) @(posedge clk);
        stray_start();
        wait_idle(100);
        repeat (20) @(posedge clk);

        // 6: reset during a burst aborts at once with no done
        start_burst(5, 1'b0, 0);
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("sclk_high_before_abort", int'(ifc.sclk), 1);
        #1;
        reset = 1'b1;
        #1;
        check("abort_sclk", int'(ifc.sclk), 0);
        check("abort_busy", int'(ifc.busy), 0);
        check("abort_done", int'(ifc.done), 0);
        model_div = 5;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (10) @(posedge clk);
        start_burst(2, 1'b0, 0);
        wait_idle(100);

        repeat (10) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
